// File: rtl/add_chunked.sv
// add_chunked -- multi-cycle adder that sums WIDTH-bit operands CHUNK bits
// per clock, rippling the carry between cycles through a register.
//
// Build option: define ADD_CHUNKED_SUB_EN to enable subtract mode (sub=1 at
// capture gives out = a - b). Without the macro, sub is ignored and every
// operation is a + b + cin.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands presented (taken only when in_ready=1)
//   in_ready   block is idle and can accept operands
//   a, b       WIDTH-bit operands
//   cin        carry-in for add mode
//   sub        subtract-mode select (only with ADD_CHUNKED_SUB_EN)
//   out_valid  result available
//   out_ready  consumer takes the result
//   out        WIDTH-bit sum/difference
//   cout       carry-out (no-borrow when subtracting)
//   ovf        signed overflow
//   zero       result equals zero
module add_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_nxt;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [CHUNK:0]   sum;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  // One chunk of the ripple: returns {carry_out, sum_bits}.
  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  // Operand conditioning at capture time. Subtraction is a + ~b + 1, so the
  // stored b is already inverted and the carry register starts at 1.
`ifdef ADD_CHUNKED_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  logic sub_unused;
  assign sub_unused = sub;
  assign b_in       = b;
  assign c_in       = cin;
`endif

  assign accept = (state == IDLE) && in_valid;
  assign last   = (idx == LAST_IDX);

  // Current chunk sum, and the full result as it will look once this chunk
  // is written (needed for ovf/zero on the final chunk).
  always_comb begin
    sum     = add_chunk(a_q[idx*CHUNK +: CHUNK], b_q[idx*CHUNK +: CHUNK], carry);
    out_nxt = out_q;
    out_nxt[idx*CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  // ---- control: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // ---- capture: operand registers (no reset, only meaningful in BUSY) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b_in;
    end
  end

  // ---- ripple: per-chunk sum, running carry and result flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      out_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            idx   <= '0;
            carry <= c_in;
          end
        end
        BUSY: begin
          out_q[idx*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
          carry <= sum[CHUNK];
          // idx wraps to 0 on the last chunk so it never points past out.
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            cout_q <= sum[CHUNK];
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (out_nxt[WIDTH-1] != a_q[WIDTH-1]);
            zero_q <= (out_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = out_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add_chunked.sv
module tb_add_chunked;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [15:0] out;
  logic        in_valid1, out_ready1;
  logic        in_ready1, out_valid1, cout1, ovf1, zero1;
  logic [15:0] out1;

  int n_checks = 0;
  int n_fail   = 0;

  add_chunked #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .cout(cout), .ovf(ovf), .zero(zero));

  add_chunked #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid1),
    .out_ready(out_ready1), .out(out1), .cout(cout1), .ovf(ovf1), .zero(zero1));

  // Reference: whole-word arithmetic. Returns {out, cout, ovf, zero}.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [16:0] full;
    logic [15:0] r;
    logic        co, ov, sub_on;
`ifdef ADD_CHUNKED_SUB_EN
    sub_on = s;
`else
    sub_on = 1'b0 & s;
`endif
    if (sub_on) begin
      r  = x - y;
      co = (x >= y);
      ov = (x[15] != y[15]) && (r[15] != x[15]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + 17'(c);
      r    = full[15:0];
      co   = full[16];
      ov   = (x[15] == y[15]) && (r[15] != x[15]);
    end
    return {r, co, ov, (r == 16'h0000)};
  endfunction

  // Issue one operation on dut; starts and ends 1 time unit after a rising edge.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                        input logic s, output int lat, output logic [18:0] res);
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {out, cout, ovf, zero};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_hs got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    n_checks++;
    if ({out, cout, ovf, zero} !== 19'h0) begin
      n_fail++; $display("FAIL reset_outs got %h exp 0", {out, cout, ovf, zero});
    end
    n_checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || {out1, cout1, ovf1, zero1} !== 19'h0) begin
      n_fail++; $display("FAIL reset_n1 got valid=%b ready=%b outs=%h", out_valid1, in_ready1, {out1, cout1, ovf1, zero1});
    end
    // in_valid while reset is held must not start anything
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out !== 16'h0) begin
      n_fail++; $display("FAIL reset_hold got ready=%b out=%h exp ready=1 out=0", in_ready, out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        c;
    logic        s;
    logic [18:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t        v[4];
    int          lat;
    logic [18:0] res;
    v[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0}};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1}};
    v[2] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, {16'h0100, 1'b0, 1'b0, 1'b0}};
`ifdef ADD_CHUNKED_SUB_EN
    v[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0}};
`else
    v[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, {16'h000C, 1'b0, 1'b0, 1'b0}};
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].x, v[i].y, v[i].c, v[i].s, lat, res);
      n_checks++;
      if (lat !== 4) begin
        n_fail++; $display("FAIL directed%0d_latency got %0d exp 4", i, lat);
      end
      n_checks++;
      if (res !== v[i].exp) begin
        n_fail++; $display("FAIL directed%0d_result got {out,cout,ovf,zero}=%h exp %h", i, res, v[i].exp);
      end
    end
  endtask

  task automatic test_random();
    int          lat;
    logic [18:0] res, exp;
    logic [15:0] x, y;
    logic        c, s;
    for (int i = 0; i < 30; i++) begin
      x = 16'($urandom); y = 16'($urandom);
      if (i % 5 == 0) y = 16'(-x);
      c = 1'($urandom); s = 1'($urandom);
      exp = model(x, y, c, s);
      run_op(x, y, c, s, lat, res);
      n_checks++;
      if (lat !== 4 || res !== exp) begin
        n_fail++; $display("FAIL random%0d got lat=%0d res=%h exp lat=4 res=%h (a=%h b=%h c=%b s=%b)", i, lat, res, exp, x, y, c, s);
      end
    end
  endtask

  task automatic test_hold();
    int          lat;
    logic [18:0] res, held;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    held = {out, cout, ovf, zero};
    n_checks++;
    if (held !== {16'h5555, 3'b000}) begin
      n_fail++; $display("FAIL hold_first got %h exp %h", held, {16'h5555, 3'b000});
    end
    a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out, cout, ovf, zero} !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL hold_cycle%0d got outs=%h ready=%b valid=%b exp outs=%h ready=0 valid=1", i, {out, cout, ovf, zero}, in_ready, out_valid, held);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {out, cout, ovf, zero} !== held) begin
      n_fail++; $display("FAIL hold_release got ready=%b valid=%b outs=%h exp ready=1 valid=0 outs=%h", in_ready, out_valid, {out, cout, ovf, zero}, held);
    end
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat, res);
    n_checks++;
    if (lat !== 4 || res !== {16'hFFFE, 3'b100}) begin
      n_fail++; $display("FAIL hold_next got lat=%0d res=%h exp lat=4 res=%h", lat, res, {16'hFFFE, 3'b100});
    end
  endtask

  task automatic test_reset_abort();
    int          lat;
    logic [18:0] res;
    logic        seen;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {out, cout, ovf, zero} !== 19'h0) begin
      n_fail++; $display("FAIL abort_in_reset got valid=%b ready=%b outs=%h exp 0/1/0", out_valid, in_ready, {out, cout, ovf, zero});
    end
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1 || out !== 16'h0) begin
      n_fail++; $display("FAIL abort_no_result got seen_valid=%b ready=%b out=%h exp 0/1/0", seen, in_ready, out);
    end
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat, res);
    n_checks++;
    if (lat !== 4 || res !== {16'h2345, 3'b000}) begin
      n_fail++; $display("FAIL abort_next got lat=%0d res=%h exp lat=4 res=%h", lat, res, {16'h2345, 3'b000});
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int waited;
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 36; cyc++) begin
      if (in_ready) q.push_back(cyc);
      if (out_valid) begin
        n_checks++;
        if (out !== 16'h1010) begin
          n_fail++; $display("FAIL b2b_result cyc%0d got %h exp 1010", cyc, out);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (q.size() != 6) begin
      n_fail++; $display("FAIL b2b_count got %0d accepts exp 6", q.size());
    end
    for (int i = 1; i < q.size(); i++) begin
      n_checks++;
      if (q[i] - q[i-1] != 6) begin
        n_fail++; $display("FAIL b2b_gap%0d got %0d exp 6", i, q[i] - q[i-1]);
      end
    end
    waited = 0;
    while (!in_ready && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_drain got ready=%b exp 1", in_ready);
    end
  endtask

  task automatic test_n1();
    int          lat;
    logic [18:0] res, exp;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        a = 16'h8000; b = 16'h8000; cin = 1'b0; sub = 1'b0;
      end else begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      exp = (i == 0) ? {16'h0000, 3'b111} : model(a, b, cin, sub);
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      res = {out1, cout1, ovf1, zero1};
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      n_checks++;
      if (lat !== 1 || res !== exp || in_ready1 !== 1'b1) begin
        n_fail++; $display("FAIL n1_op%0d got lat=%0d res=%h ready=%b exp lat=1 res=%h ready=1", i, lat, res, in_ready1, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    test_n1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_chunked.md
ADD_CHUNKED -- requirements
Module: add_chunked

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits summed per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, with N = WIDTH/CHUNK.
REQ-003 SHALL have port CLK, input, 1 bit, single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port IN_VALID, input, 1 bit, operands presented.
REQ-006 SHALL have port IN_READY, output, 1 bit, block can accept operands.
REQ-007 SHALL have ports A and B, input, WIDTH bits each, operands.
REQ-008 SHALL have port CIN, input, 1 bit, carry-in for add mode.
REQ-009 SHALL have port SUB, input, 1 bit, subtract-mode select (see Configuration).
REQ-010 SHALL have port OUT_VALID, output, 1 bit, result available.
REQ-011 SHALL have port OUT_READY, input, 1 bit, consumer takes the result.
REQ-012 SHALL have port OUT, output, WIDTH bits, sum/difference.
REQ-013 SHALL have ports COUT, OVF and ZERO, output, 1 bit each: carry-out (no-borrow in subtract), signed overflow, result equals zero.

Function
REQ-014 SHALL implement states IDLE, BUSY, DONE; IN_READY = (state==IDLE); OUT_VALID = (state==DONE).
REQ-015 In IDLE, IN_VALID=1 at an edge SHALL register A, B, CIN, SUB, clear chunk index to 0, clear the running carry to CIN (add) or 1 (subtract), and enter BUSY.
REQ-016 Each BUSY cycle SHALL add chunk i of A and chunk i of B' (B' = ~B in subtract, else B) plus the running carry, write OUT[i*CHUNK +: CHUNK], update the running carry, and increment i.
REQ-017 After the chunk with i = N-1 the block SHALL enter DONE; OUT_VALID SHALL rise exactly N cycles after the accepting edge.
REQ-018 On entering DONE: COUT SHALL equal the final carry; OVF SHALL equal (A[MSB]==B'[MSB]) && (OUT[MSB]!=A[MSB]); ZERO SHALL equal (OUT==0).
REQ-019 OUT, COUT, OVF and ZERO SHALL hold stable in DONE until an edge with OUT_READY=1, which SHALL return the block to IDLE.
REQ-020 OUT, COUT, OVF and ZERO SHALL retain their last values in IDLE and SHALL be valid only while OUT_VALID=1.
REQ-021 IN_VALID in BUSY or DONE SHALL be ignored (no capture, no corruption); back-to-back issue rate SHALL be at most one operation per N+2 cycles.
REQ-022 Arithmetic SHALL wrap modulo 2^WIDTH; carry beyond the MSB SHALL appear only on COUT.
REQ-023 With CHUNK = WIDTH (N=1), the block SHALL complete in one BUSY cycle with the same handshake.

Reset
REQ-024 RST_N low SHALL immediately force state IDLE and clear the chunk index, running carry, OUT, COUT, OVF and ZERO to 0; OUT_VALID=0 and IN_READY=1 while reset is held.
REQ-025 Reset asserted during BUSY or DONE SHALL abort the operation with no result delivered; the first edge after release SHALL be able to accept new operands.

Configuration
REQ-026 Macro ADD_CHUNKED_SUB_EN defined: SUB=1 at capture SHALL select OUT = A - B (B inverted, carry-in forced 1, CIN ignored).
REQ-027 Macro ADD_CHUNKED_SUB_EN undefined: SUB SHALL be ignored, every operation SHALL be A + B + CIN, and no inversion logic SHALL be synthesised.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-028 A=0x7FFF, B=0x0001, CIN=0, SUB=0 -> OUT_VALID 4 cycles after accept; OUT=0x8000, COUT=0, OVF=1, ZERO=0.
REQ-029 A=0xFFFF, B=0x0001, CIN=0 -> OUT=0x0000, COUT=1, OVF=0, ZERO=1; A=0x00FF, B=0x0000, CIN=1 -> OUT=0x0100.
REQ-030 SUB=1, A=0x0005, B=0x0007: with the macro -> OUT=0xFFFE, COUT=0; without the macro -> OUT=0x000C, COUT=0.
REQ-031 OUT_READY held low 5 cycles in DONE with IN_VALID=1 and new operands -> outputs unchanged, IN_READY=0, no capture; OUT_READY=1 -> IDLE next cycle, then accept.
REQ-032 RST_N pulsed low in the 2nd BUSY cycle -> OUT_VALID never asserts, OUT=0, IN_READY=1; a following 0x1234+0x1111 -> OUT=0x2345.
REQ-033 WIDTH=16, CHUNK=16: 0x8000+0x8000 -> OUT_VALID 1 cycle after accept; OUT=0x0000, COUT=1, OVF=1, ZERO=1.
